// File: rtl/hs4_if.sv
// Link- and stream-side signals of the 4-phase receiver.
// The names follow the upstream link and the downstream valid/ready stream.
interface hs4_if #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
);
  logic                     req_i;
  logic [DW-1:0]            data_i;
  logic                     ack_o;
  logic [DW-1:0]            data_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [$clog2(DEPTH):0]   level_o;

  // Handshakes:
  // - Upstream link is 4-phase. req_i rises with data_i stable, and ack_o rises once
  //   the word is stored. req_i then falls, and ack_o falls after that.
  // - Downstream stream: a word transfers on every rising clk where valid_o & ready_i.
  //   valid_o stays high, and data_o stays stable, until the word is taken.
  modport slave (
    input  req_i, data_i, ready_i,
    output ack_o, data_o, valid_o, level_o
  );

  modport master (
    output req_i, data_i, ready_i,
    input  ack_o, data_o, valid_o, level_o
  );
endinterface

// File: rtl/hs4_receiver.sv
// Sink of a 4-phase req/ack link: captures one word per request phase into a
// first-word-fall-through FIFO and presents it on a valid/ready stream.
module hs4_receiver #(
  parameter int DW          = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  hs4_if.slave       bus,
  output logic [1:0] state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // REL is encoded as bit 1 alone, so ack_o comes straight from one flop.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CAPT = 2'b01,
    REL  = 2'b10
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            req_s;
  logic            wr_en;
  logic            ack;
  logic            pop;
  logic            full;
  logic            valid;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = bus.req_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= bus.req_i;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
          end
        end
      end

      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // The full test uses the registered level, so a same-cycle pop is not bypassed.
  assign full  = (level == LW'(DEPTH));
  assign valid = (level != '0);
  assign pop   = valid & bus.ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_s && !full) state_nxt = CAPT;
      CAPT:    state_nxt = REL;
      REL:     if (!req_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_en = 1'b0;
    ack   = 1'b0;
    case (state)
      CAPT:    wr_en = 1'b1;
      REL:     ack   = 1'b1;
      default: begin
        wr_en = 1'b0;
        ack   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wr_ptr] <= bus.data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign bus.ack_o   = ack;
  assign bus.valid_o = valid;
  assign bus.data_o  = valid ? mem[rd_ptr] : '0;
  assign bus.level_o = level;
  assign state_dbg   = state;

endmodule

// File: tb/tb_hs4_receiver.sv
// Directed bench for hs4_receiver: a vector table on a same-clock instance, a pop
// scoreboard on its stream side, and a latency sequence on a synchronised instance.
module tb_hs4_receiver;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  typedef struct {
    logic          rst;
    logic          req;
    logic [DW-1:0] data;
    logic          ready;
    logic          ack;
    logic          valid;
    logic [DW-1:0] dout;
    logic [2:0]    level;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] state0;
  logic [1:0] state1;
  int n_vec = 0;
  int n_err = 0;
  vec_t vecs[$];
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  hs4_if #(.DW(DW), .DEPTH(DEPTH)) bus0 ();
  hs4_if #(.DW(DW), .DEPTH(DEPTH)) bus1 ();

  hs4_receiver #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .state_dbg(state0)
  );

  hs4_receiver #(.DW(DW), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .state_dbg(state1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic q, input logic [DW-1:0] d, input logic rd,
                     input logic a, input logic v, input logic [DW-1:0] o, input logic [2:0] l);
    vec_t t;
    t.rst = r; t.req = q; t.data = d; t.ready = rd;
    t.ack = a; t.valid = v; t.dout = o; t.level = l;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack1(input logic lvl, output int edges);
    edges = 0;
    while (bus1.ack_o !== lvl && edges < 20) begin
      tick();
      edges++;
    end
  endtask

  // Every accepted word on dut0's stream must match the next expected word.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus0.valid_o === 1'b1 && bus0.ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("sb unexpected pop", 32'(bus0.data_o), 32'hFFFF_FFFF);
      end else begin
        check("sb pop data", 32'(bus0.data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [DW-1:0] d;

    bus0.req_i = 1'b0; bus0.data_i = '0; bus0.ready_i = 1'b0;
    bus1.req_i = 1'b0; bus1.data_i = '0; bus1.ready_i = 1'b0;

    // Reset
    add(1, 0, 8'h00, 0,  0, 0, 8'h00, 0);
    add(1, 0, 8'h00, 0,  0, 0, 8'h00, 0);
    // Single word: ack two edges after req, released one edge after req drops
    add(0, 1, 8'hA5, 0,  0, 0, 8'h00, 0);
    add(0, 1, 8'hA5, 0,  1, 1, 8'hA5, 1);
    add(0, 0, 8'hA5, 0,  0, 1, 8'hA5, 1);
    add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0);
    exp_q.push_back(8'hA5);
    // Back-to-back with ready held high
    for (int k = 1; k <= 6; k++) begin
      d = DW'(k);
      add(0, 1, d, 1,  0, 0, 8'h00, 0);
      add(0, 1, d, 1,  1, 1, d,     1);
      add(0, 0, d, 1,  0, 0, 8'h00, 0);
      exp_q.push_back(d);
    end
    // Backpressure: four words fill the FIFO
    for (int k = 1; k <= 4; k++) begin
      d = DW'(8'h10 + k);
      add(0, 1, d, 0,  0, k > 1, (k > 1) ? 8'h11 : 8'h00, 3'(k - 1));
      add(0, 1, d, 0,  1, 1, 8'h11, 3'(k));
      add(0, 0, d, 0,  0, 1, 8'h11, 3'(k));
      exp_q.push_back(d);
    end
    // Fifth request held off while full, then released by a single pop
    add(0, 1, 8'h15, 0,  0, 1, 8'h11, 4);
    add(0, 1, 8'h15, 0,  0, 1, 8'h11, 4);
    add(0, 1, 8'h15, 1,  0, 1, 8'h12, 3);
    add(0, 1, 8'h15, 0,  0, 1, 8'h12, 3);
    add(0, 1, 8'h15, 0,  1, 1, 8'h12, 4);
    add(0, 0, 8'h15, 0,  0, 1, 8'h12, 4);
    add(0, 0, 8'h00, 1,  0, 1, 8'h13, 3);
    add(0, 0, 8'h00, 1,  0, 1, 8'h14, 2);
    add(0, 0, 8'h00, 1,  0, 1, 8'h15, 1);
    add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0);
    exp_q.push_back(8'h15);
    // Simultaneous write and pop at level 2, across pointer wrap
    add(0, 1, 8'h21, 0,  0, 0, 8'h00, 0);
    add(0, 1, 8'h21, 0,  1, 1, 8'h21, 1);
    add(0, 0, 8'h21, 0,  0, 1, 8'h21, 1);
    add(0, 1, 8'h22, 0,  0, 1, 8'h21, 1);
    add(0, 1, 8'h22, 0,  1, 1, 8'h21, 2);
    add(0, 0, 8'h22, 0,  0, 1, 8'h21, 2);
    exp_q.push_back(8'h21);
    exp_q.push_back(8'h22);
    for (int j = 3; j <= 8; j++) begin
      d = DW'(8'h20 + j);
      add(0, 1, d, 0,  0, 1, d - 8'd2, 2);
      add(0, 1, d, 1,  1, 1, d - 8'd1, 2);
      add(0, 0, d, 0,  0, 1, d - 8'd1, 2);
      exp_q.push_back(d);
    end
    add(0, 0, 8'h00, 1,  0, 1, 8'h28, 1);
    add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0);
    // Reset while in REL with two words buffered; held req is a fresh transfer
    add(0, 1, 8'h31, 0,  0, 0, 8'h00, 0);
    add(0, 1, 8'h31, 0,  1, 1, 8'h31, 1);
    add(0, 0, 8'h31, 0,  0, 1, 8'h31, 1);
    add(0, 1, 8'h32, 0,  0, 1, 8'h31, 1);
    add(0, 1, 8'h32, 0,  1, 1, 8'h31, 2);
    add(1, 1, 8'h32, 0,  0, 0, 8'h00, 0);
    add(0, 1, 8'h33, 0,  0, 0, 8'h00, 0);
    add(0, 1, 8'h33, 0,  1, 1, 8'h33, 1);
    add(0, 0, 8'h33, 0,  0, 1, 8'h33, 1);
    add(0, 0, 8'h00, 1,  0, 0, 8'h00, 0);
    exp_q.push_back(8'h33);

    for (int i = 0; i < vecs.size(); i++) begin
      rst          = vecs[i].rst;
      bus0.req_i   = vecs[i].req;
      bus0.data_i  = vecs[i].data;
      bus0.ready_i = vecs[i].ready;
      tick();
      check($sformatf("vec%0d ack", i),   32'(bus0.ack_o),   32'(vecs[i].ack));
      check($sformatf("vec%0d valid", i), 32'(bus0.valid_o), 32'(vecs[i].valid));
      check($sformatf("vec%0d data", i),  32'(bus0.data_o),  32'(vecs[i].dout));
      check($sformatf("vec%0d level", i), 32'(bus0.level_o), 32'(vecs[i].level));
    end
    bus0.req_i = 1'b0;
    bus0.ready_i = 1'b0;

    // Two synchroniser stages: ack rises 4 edges after req and falls 3 after release
    bus1.data_i = 8'h5A;
    bus1.req_i  = 1'b1;
    wait_ack1(1'b1, e);
    check("sync2 ack rise edges", 32'(e), 32'd4);
    check("sync2 data", 32'(bus1.data_o), 32'h5A);
    check("sync2 level", 32'(bus1.level_o), 32'd1);
    bus1.req_i = 1'b0;
    wait_ack1(1'b0, e);
    check("sync2 ack fall edges", 32'(e), 32'd3);
    bus1.ready_i = 1'b1;
    tick();
    bus1.ready_i = 1'b0;
    check("sync2 drained level", 32'(bus1.level_o), 32'd0);
    check("sync2 drained valid", 32'(bus1.valid_o), 32'd0);

    tick();
    check("sb remaining words", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
